// File: rtl/logic_gates_exerciser.sv
// Self-test driver for the two-input gate block: walks all four (a,b) combinations,
// samples the seven gate outputs after a settle interval and accumulates mismatches.
module logic_gates_exerciser #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [6:0] o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask,
  output logic [6:0] last_obs
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [2:0] r_errCount;
  logic [3:0] r_failMask;
  logic [6:0] r_lastObs;
  logic       r_pass;
  logic [6:0] w_expected;
  logic       w_mismatch;
  logic [2:0] w_errNext;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE:  if (start) w_nextState = DRIVE;
      DRIVE: begin
        busy = 1'b1;
        if (r_cnt == LAST_CNT) w_nextState = CHECK;
      end
      CHECK: begin
        busy        = 1'b1;
        w_nextState = (r_idx == 2'd3) ? DONE : DRIVE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_expected = 7'h6C;
    case (r_idx)
      2'd0: w_expected = 7'h6C;
      2'd1: w_expected = 7'h56;
      2'd2: w_expected = 7'h16;
      2'd3: w_expected = 7'h23;
      default: w_expected = 7'h6C;
    endcase
  end

  // Written so that an unknown value on o falls through to a mismatch.
  always_comb begin
    w_mismatch = 1'b1;
    if (o == w_expected) w_mismatch = 1'b0;
    w_errNext = r_errCount + 3'(w_mismatch);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx      <= 2'd0;
      r_cnt      <= 4'd0;
      r_errCount <= 3'd0;
      r_failMask <= 4'd0;
      r_lastObs  <= 7'd0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx      <= 2'd0;
            r_cnt      <= 4'd0;
            r_errCount <= 3'd0;
            r_failMask <= 4'd0;
            r_lastObs  <= 7'd0;
            r_pass     <= 1'b0;
          end
        end
        DRIVE: r_cnt <= r_cnt + 4'd1;
        CHECK: begin
          r_lastObs  <= o;
          r_errCount <= w_errNext;
          if (w_mismatch) r_failMask[r_idx] <= 1'b1;
          // pass is decided here so it already includes this final check when DONE shows
          if (r_idx == 2'd3) begin
            r_pass <= (w_errNext == 3'd0);
          end else begin
            r_idx <= r_idx + 2'd1;
            r_cnt <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign a         = r_idx[1];
  assign b         = r_idx[0];
  assign pass      = r_pass;
  assign err_count = r_errCount;
  assign fail_mask = r_failMask;
  assign last_obs  = r_lastObs;

endmodule

// File: tb/tb_logic_gates_exerciser.sv
// Randomized bench for logic_gates_exerciser: two instances (SETTLE=2 with injectable
// gate faults, SETTLE=1 with start held high) checked every cycle against a timeline model.
module tb_logic_gates_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start0, start1;
  logic       a0, b0, a1, b1;
  logic [6:0] o0, o1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] mask0, mask1;
  logic [6:0] last0, last1;
  logic [6:0] fm [4];

  int assertCount = 0;
  int failCount   = 0;

  function automatic logic [6:0] gateOut(input logic ga, input logic gb);
    return {~ga, ~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ga | gb, ga & gb};
  endfunction

  function automatic logic [6:0] expOf(input int j);
    case (j)
      0: return 7'h6C;
      1: return 7'h56;
      2: return 7'h16;
      default: return 7'h23;
    endcase
  endfunction

  assign o0 = gateOut(a0, b0) ^ fm[{a0, b0}];
  assign o1 = gateOut(a1, b1);

  logic_gates_exerciser #(.SETTLE(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .o(o0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_mask(mask0), .last_obs(last0)
  );

  logic_gates_exerciser #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .o(o1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_mask(mask1), .last_obs(last1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: t is the number of edges since start was accepted (-1 when idle);
  // combination j is judged on the edge where t reaches (j+1)*period.
  int         mT   [2];
  int         mPer [2];
  logic [2:0] mErr [2];
  logic [3:0] mMask[2];
  logic [6:0] mLast[2];
  logic       mPass[2];
  bit         modelReady = 0;
  int         cyc = 0;
  int         rstCount = 0;

  initial begin
    mPer[0] = 3;
    mPer[1] = 2;
  end

  always @(posedge clk) begin
    logic       st;
    logic [6:0] f;
    int         j;
    cyc++;
    if (!rst_n) rstCount++;
    for (int i = 0; i < 2; i++) begin
      st = (i == 0) ? start0 : start1;
      if (!rst_n) begin
        mT[i] = -1; mErr[i] = 0; mMask[i] = 0; mLast[i] = 0; mPass[i] = 0;
        modelReady = 1;
      end else if (mT[i] == -1) begin
        if (st) begin
          mT[i] = 0; mErr[i] = 0; mMask[i] = 0; mLast[i] = 0; mPass[i] = 0;
        end
      end else if (mT[i] == 4 * mPer[i]) begin
        mT[i] = -1;
      end else begin
        mT[i]++;
        if (mT[i] % mPer[i] == 0) begin
          j = mT[i] / mPer[i] - 1;
          f = (i == 0) ? fm[j] : 7'h00;
          mLast[i] = expOf(j) ^ f;
          if (f != 7'h00) begin
            mErr[i]++;
            mMask[i][j] = 1'b1;
          end
          if (j == 3) mPass[i] = (mErr[i] == 0);
        end
      end
    end
  end

  int prevDone1 = -1;
  int rstSnap   = 0;

  always @(negedge clk) begin
    logic       vBusy, vDone, vPass, vA, vB;
    logic [2:0] vErr;
    logic [3:0] vMask;
    logic [6:0] vLast;
    int         idx;
    if (modelReady) begin
      for (int i = 0; i < 2; i++) begin
        vBusy = (i == 0) ? busy0 : busy1;
        vDone = (i == 0) ? done0 : done1;
        vPass = (i == 0) ? pass0 : pass1;
        vA    = (i == 0) ? a0 : a1;
        vB    = (i == 0) ? b0 : b1;
        vErr  = (i == 0) ? err0 : err1;
        vMask = (i == 0) ? mask0 : mask1;
        vLast = (i == 0) ? last0 : last1;
        checkOutput($sformatf("u%0d busy", i), 32'(vBusy), 32'(mT[i] >= 0 && mT[i] < 4 * mPer[i]));
        checkOutput($sformatf("u%0d done", i), 32'(vDone), 32'(mT[i] == 4 * mPer[i]));
        checkOutput($sformatf("u%0d err_count", i), 32'(vErr), 32'(mErr[i]));
        checkOutput($sformatf("u%0d fail_mask", i), 32'(vMask), 32'(mMask[i]));
        checkOutput($sformatf("u%0d last_obs", i), 32'(vLast), 32'(mLast[i]));
        checkOutput($sformatf("u%0d pass", i), 32'(vPass), 32'(mPass[i]));
        if (mT[i] >= 0 && mT[i] < 4 * mPer[i]) begin
          idx = mT[i] / mPer[i];
          checkOutput($sformatf("u%0d ab", i), 32'({vA, vB}), 32'(idx));
        end
      end
      if (done1 === 1'b1) begin
        if (prevDone1 >= 0 && rstSnap == rstCount)
          checkOutput("u1 done period", 32'(cyc - prevDone1), 32'd10);
        prevDone1 = cyc;
        rstSnap   = rstCount;
      end
    end
  end

  task automatic waitDone(input string name);
    bit seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) seen = 1;
    end
    checkOutput({name, " done seen"}, 32'(seen), 32'd1);
  endtask

  task automatic applyStimulus(input logic [6:0] f0, input logic [6:0] f1,
                               input logic [6:0] f2, input logic [6:0] f3, input string name);
    @(negedge clk);
    fm[0] = f0; fm[1] = f1; fm[2] = f2; fm[3] = f3;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    waitDone(name);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int doneCnt;
    int nz;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    for (int j = 0; j < 4; j++) fm[j] = 7'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset busy", 32'(busy0), 32'd0);
    checkOutput("reset ab", 32'({a0, b0}), 32'd0);
    checkOutput("reset pass", 32'(pass0), 32'd0);
    checkOutput("reset last_obs", 32'(last0), 32'd0);
    start1 = 1'b1;

    $display("[TB] ideal run");
    applyStimulus(7'h00, 7'h00, 7'h00, 7'h00, "ideal");
    checkOutput("ideal pass", 32'(pass0), 32'd1);
    checkOutput("ideal err", 32'(err0), 32'd0);
    checkOutput("ideal mask", 32'(mask0), 32'd0);
    checkOutput("ideal last_obs", 32'(last0), 32'h23);

    $display("[TB] o[6] stuck at 0");
    applyStimulus(7'h40, 7'h40, 7'h00, 7'h00, "stuck");
    checkOutput("stuck pass", 32'(pass0), 32'd0);
    checkOutput("stuck err", 32'(err0), 32'd2);
    checkOutput("stuck mask", 32'(mask0), 32'b0011);

    $display("[TB] o[4] inverted");
    applyStimulus(7'h10, 7'h10, 7'h10, 7'h10, "xorinv");
    checkOutput("xorinv err", 32'(err0), 32'd4);
    checkOutput("xorinv mask", 32'(mask0), 32'b1111);
    checkOutput("xorinv pass", 32'(pass0), 32'd0);
    checkOutput("xorinv last_obs", 32'(last0), 32'h33);

    $display("[TB] second start mid-run");
    @(negedge clk);
    fm[0] = 7'h00; fm[1] = 7'h00; fm[2] = 7'h00; fm[3] = 7'h00;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) doneCnt++;
    end
    checkOutput("restart done count", 32'(doneCnt), 32'd1);
    checkOutput("restart pass", 32'(pass0), 32'd1);

    $display("[TB] reset during idx 2");
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort busy", 32'(busy0), 32'd0);
    checkOutput("abort ab", 32'({a0, b0}), 32'd0);
    checkOutput("abort err", 32'(err0), 32'd0);
    doneCnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) doneCnt++;
    end
    checkOutput("abort no done", 32'(doneCnt), 32'd0);
    applyStimulus(7'h00, 7'h00, 7'h00, 7'h00, "post-abort");
    checkOutput("post-abort pass", 32'(pass0), 32'd1);

    $display("[TB] random fault runs");
    for (int r = 0; r < 16; r++) begin
      logic [6:0] rf [4];
      nz = 0;
      for (int j = 0; j < 4; j++) begin
        rf[j] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'h00;
        if (rf[j] != 7'h00) nz++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(rf[0], rf[1], rf[2], rf[3], "random");
      checkOutput("random err", 32'(err0), 32'(nz));
      checkOutput("random pass", 32'(pass0), 32'(nz == 0));
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
